// File: rtl/mem_dma_if.sv
// mem_dma_if: command and data-memory port bundle between mem_dma and its environment
interface mem_dma_if #(
   parameter int WIDTH        = 16,
   parameter int D_ADDR_WIDTH = 8
);
   logic                    start;
   logic                    mode;
   logic [D_ADDR_WIDTH-1:0] src;
   logic [D_ADDR_WIDTH-1:0] dst;
   logic [D_ADDR_WIDTH-1:0] len;
   logic [WIDTH-1:0]        fill_val;
   logic                    busy;
   logic                    done;
   logic                    mem_write;
   logic [D_ADDR_WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0]        mem_wdata;
   logic [WIDTH-1:0]        mem_rdata;
   modport master (
      input  start, mode, src, dst, len, fill_val, mem_rdata,
      output busy, done, mem_write, mem_addr, mem_wdata
   );
   modport slave (
      output start, mode, src, dst, len, fill_val, mem_rdata,
      input  busy, done, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_dma.sv
// mem_dma: single-channel block copy / block fill DMA on a combinational-read, sync-write memory
module mem_dma #(
   parameter int WIDTH        = 16,
   parameter int D_ADDR_WIDTH = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   mem_dma_if.master bus
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   state_t                  r_state, w_next;
   logic [D_ADDR_WIDTH-1:0] r_sptr, r_dptr, r_cnt;
   logic                    r_mode;
   logic [WIDTH-1:0]        r_fill, r_buf;
   logic                    w_busy, w_done, w_write;
   logic [D_ADDR_WIDTH-1:0] w_addr;
   logic [WIDTH-1:0]        w_wdata;
   // state register; async reset returns to IDLE so a pending write is dropped at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end
   // command latch on accepted start, then pointer/counter/buffer advance per word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sptr <= '0;
         r_dptr <= '0;
         r_cnt  <= '0;
         r_mode <= 1'b0;
         r_fill <= '0;
         r_buf  <= '0;
      end else begin
         case (r_state)
            IDLE: if (bus.start) begin
               r_sptr <= bus.src;
               r_dptr <= bus.dst;
               r_cnt  <= bus.len;
               r_mode <= bus.mode;
               r_fill <= bus.fill_val;
            end
            READ: begin
               r_buf  <= bus.mem_rdata;
               r_sptr <= r_sptr + 1'b1;
            end
            WRITE: begin
               r_dptr <= r_dptr + 1'b1;
               r_cnt  <= r_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end
   // next state and memory/status outputs, decoded from registered state only
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = (bus.len == '0) ? DONE : (bus.mode ? WRITE : READ);
         READ:    w_next = WRITE;
         WRITE:   w_next = (r_cnt == D_ADDR_WIDTH'(1)) ? DONE : (r_mode ? WRITE : READ);
         default: w_next = IDLE;
      endcase
      w_busy  = (r_state == READ) || (r_state == WRITE);
      w_done  = (r_state == DONE);
      w_write = (r_state == WRITE);
      w_addr  = (r_state == READ) ? r_sptr : (r_state == WRITE) ? r_dptr : '0;
      w_wdata = (r_state == WRITE) ? (r_mode ? r_fill : r_buf) : '0;
   end
   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.mem_write = w_write;
   assign bus.mem_addr  = w_addr;
   assign bus.mem_wdata = w_wdata;
endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: randomized and directed checks of mem_dma against a golden memory model
module tb_mem_dma;
   localparam int W = 16;
   localparam int A = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   mem_dma_if #(.WIDTH(W), .D_ADDR_WIDTH(A)) bus();
   mem_dma #(.WIDTH(W), .D_ADDR_WIDTH(A)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   logic [W-1:0] mem  [256];
   logic [W-1:0] gmem [256];
   logic         pre_we = 1'b0;
   logic [A-1:0] pre_a  = '0;
   logic [W-1:0] pre_d  = '0;
   assign bus.mem_rdata = mem[bus.mem_addr];
   // memory: combinational read, synchronous write; bench preload port takes priority
   always @(posedge clk) begin
      if (pre_we) mem[pre_a] <= pre_d;
      else if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
   end
   int n_chk = 0;
   int n_fail = 0;
   logic [A-1:0] wq[$];
   logic [A-1:0] rq[$];
   int nbusy, ndone, done_at;

   task automatic poke(input logic [A-1:0] a, input logic [W-1:0] d);
      pre_we = 1'b1; pre_a = a; pre_d = d; gmem[a] = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // golden model: ascending word-by-word transfer on a plain array
   task automatic apply(input logic m, input logic [A-1:0] s, input logic [A-1:0] d, input logic [A-1:0] l, input logic [W-1:0] f);
      logic [A-1:0] sa, da;
      sa = s; da = d;
      for (int i = 0; i < int'(l); i++) begin
         gmem[da] = m ? f : gmem[sa];
         sa = sa + 1'b1; da = da + 1'b1;
      end
   endtask

   function automatic int mem_diffs();
      int n = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== gmem[i]) n++;
      return n;
   endfunction

   function automatic bit seq_ok(input logic [A-1:0] q[$], input logic [A-1:0] base, input int n);
      logic [A-1:0] e;
      e = base;
      if (q.size() != n) return 1'b0;
      for (int i = 0; i < n; i++) begin
         if (q[i] !== e) return 1'b0;
         e = e + 1'b1;
      end
      return 1'b1;
   endfunction

   // issue one command at a negedge and observe win cycles after the accepting edge
   task automatic run(input logic m, input logic [A-1:0] s, input logic [A-1:0] d, input logic [A-1:0] l, input logic [W-1:0] f, input int win);
      bus.start = 1'b1; bus.mode = m; bus.src = s; bus.dst = d; bus.len = l; bus.fill_val = f;
      wq = {}; rq = {}; nbusy = 0; ndone = 0; done_at = -1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.mode = 1'($urandom); bus.src = A'($urandom); bus.dst = A'($urandom);
      bus.len = A'($urandom); bus.fill_val = W'($urandom);
      for (int c = 1; c <= win; c++) begin
         if (bus.busy) nbusy++;
         if (bus.done) begin ndone++; done_at = c; end
         if (bus.mem_write) wq.push_back(bus.mem_addr);
         else if (bus.busy) rq.push_back(bus.mem_addr);
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0; bus.fill_val = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({bus.busy, bus.done, bus.mem_write, bus.mem_addr, bus.mem_wdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b done=%b wr=%b addr=%h wdata=%h, want all 0",
                  bus.busy, bus.done, bus.mem_write, bus.mem_addr, bus.mem_wdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 256; i++) poke(A'(i), W'($urandom));
   endtask

   task automatic test_fill();
      run(1'b1, 8'h00, 8'h10, 8'd4, 16'hBEEF, 8);
      apply(1'b1, 8'h00, 8'h10, 8'd4, 16'hBEEF);
      n_chk++; if (nbusy !== 4) begin n_fail++; $display("FAIL fill_busy: got %0d want 4", nbusy); end
      n_chk++; if (done_at !== 5 || ndone !== 1) begin n_fail++; $display("FAIL fill_done: at %0d count %0d want at 5 count 1", done_at, ndone); end
      n_chk++; if (!seq_ok(wq, 8'h10, 4)) begin n_fail++; $display("FAIL fill_waddr: %0d writes, want 4 at 10..13", wq.size()); end
      n_chk++; if (mem_diffs() != 0) begin n_fail++; $display("FAIL fill_mem: %0d words differ, want 0", mem_diffs()); end
   endtask

   task automatic test_copy();
      poke(8'h00, 16'h1111); poke(8'h01, 16'h2222); poke(8'h02, 16'h3333);
      run(1'b0, 8'h00, 8'h40, 8'd3, 16'h0, 10);
      apply(1'b0, 8'h00, 8'h40, 8'd3, 16'h0);
      n_chk++; if (nbusy !== 6) begin n_fail++; $display("FAIL copy_busy: got %0d want 6", nbusy); end
      n_chk++; if (done_at !== 7 || ndone !== 1) begin n_fail++; $display("FAIL copy_done: at %0d count %0d want at 7 count 1", done_at, ndone); end
      n_chk++; if (!seq_ok(rq, 8'h00, 3) || !seq_ok(wq, 8'h40, 3)) begin n_fail++; $display("FAIL copy_addr: %0d reads %0d writes, want 3/3", rq.size(), wq.size()); end
      n_chk++; if (mem[8'h42] !== 16'h3333 || mem_diffs() != 0) begin n_fail++; $display("FAIL copy_mem: mem[42]=%h, %0d diffs, want 3333 and 0", mem[8'h42], mem_diffs()); end
   endtask

   task automatic test_wrap();
      poke(8'hFE, 16'hA0A0); poke(8'hFF, 16'hB1B1); poke(8'h00, 16'hC2C2);
      run(1'b0, 8'hFE, 8'h20, 8'd3, 16'h0, 10);
      apply(1'b0, 8'hFE, 8'h20, 8'd3, 16'h0);
      n_chk++; if (!seq_ok(rq, 8'hFE, 3)) begin n_fail++; $display("FAIL wrap_raddr: %0d reads, want FE,FF,00", rq.size()); end
      n_chk++; if (mem[8'h22] !== 16'hC2C2 || mem_diffs() != 0) begin n_fail++; $display("FAIL wrap_mem: mem[22]=%h, %0d diffs, want C2C2 and 0", mem[8'h22], mem_diffs()); end
   endtask

   task automatic test_len0();
      run(1'b1, 8'h00, 8'h50, 8'd0, 16'hDEAD, 4);
      n_chk++; if (done_at !== 1 || ndone !== 1) begin n_fail++; $display("FAIL len0_done: at %0d count %0d want at 1 count 1", done_at, ndone); end
      n_chk++; if (nbusy !== 0 || wq.size() !== 0) begin n_fail++; $display("FAIL len0_idle: busy %0d writes %0d, want 0/0", nbusy, wq.size()); end
      n_chk++; if (mem_diffs() != 0) begin n_fail++; $display("FAIL len0_mem: %0d diffs, want 0", mem_diffs()); end
   endtask

   task automatic test_hold_start();
      logic [4:0] bv, dv;
      int nw;
      bv = '0; dv = '0; nw = 0;
      bus.start = 1'b1; bus.mode = 1'b1; bus.dst = 8'h80; bus.len = 8'd2; bus.fill_val = 16'h1234;
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         bv[c] = bus.busy; dv[c] = bus.done;
         if (c < 4 && bus.mem_write) nw++;
         @(negedge clk);
      end
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      apply(1'b1, 8'h00, 8'h80, 8'd2, 16'h1234);
      n_chk++; if (bv !== 5'b10011 || dv !== 5'b00100) begin n_fail++; $display("FAIL hold_pattern: busy %b done %b want 10011 00100", bv, dv); end
      n_chk++; if (nw !== 2) begin n_fail++; $display("FAIL hold_writes: got %0d want 2", nw); end
      n_chk++; if (mem_diffs() != 0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL hold_end: %0d diffs busy %b, want 0/0", mem_diffs(), bus.busy); end
   endtask

   task automatic test_reset_mid();
      poke(8'h30, 16'h7777); poke(8'h31, 16'h8888); poke(8'h32, 16'h9999);
      bus.start = 1'b1; bus.mode = 1'b0; bus.src = 8'h30; bus.dst = 8'h60; bus.len = 8'd3;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      n_chk++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 8'h60) begin n_fail++; $display("FAIL rstmid_pre: wr=%b addr=%h want 1/60", bus.mem_write, bus.mem_addr); end
      rst_n = 1'b0;
      #1;
      n_chk++; if ({bus.mem_write, bus.busy, bus.done} !== 3'b000) begin n_fail++; $display("FAIL rstmid_drop: wr/busy/done=%b want 000", {bus.mem_write, bus.busy, bus.done}); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++; if (mem_diffs() != 0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_nowrite: %0d diffs busy %b want 0/0", mem_diffs(), bus.busy); end
      run(1'b1, 8'h00, 8'h60, 8'd2, 16'h4242, 6);
      apply(1'b1, 8'h00, 8'h60, 8'd2, 16'h4242);
      n_chk++; if (done_at !== 3 || mem_diffs() != 0) begin n_fail++; $display("FAIL rstmid_after: done at %0d, %0d diffs, want 3/0", done_at, mem_diffs()); end
   endtask

   task automatic test_random();
      logic m;
      logic [A-1:0] s, d, l;
      logic [W-1:0] f;
      for (int it = 0; it < 10; it++) begin
         m = 1'($urandom); s = A'($urandom); d = A'($urandom);
         l = A'($urandom_range(1, 24)); f = W'($urandom);
         run(m, s, d, l, f, 2 * int'(l) + 4);
         apply(m, s, d, l, f);
         n_chk++; if (nbusy !== (m ? int'(l) : 2 * int'(l))) begin n_fail++; $display("FAIL rand_busy[%0d]: got %0d mode %b len %0d", it, nbusy, m, l); end
         n_chk++; if (ndone !== 1 || done_at !== (m ? int'(l) + 1 : 2 * int'(l) + 1)) begin n_fail++; $display("FAIL rand_done[%0d]: at %0d count %0d mode %b len %0d", it, done_at, ndone, m, l); end
         n_chk++; if (!seq_ok(wq, d, int'(l)) || (!m && !seq_ok(rq, s, int'(l)))) begin n_fail++; $display("FAIL rand_addr[%0d]: %0d reads %0d writes want %0d", it, rq.size(), wq.size(), l); end
         n_chk++; if (mem_diffs() != 0) begin n_fail++; $display("FAIL rand_mem[%0d]: %0d diffs want 0", it, mem_diffs()); end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_copy();
      test_wrap();
      test_len0();
      test_hold_start();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
